// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: elastic MEM->WB pipeline register.
// Carries WB control, result word and destination index through STAGES
// back-to-back slots with a valid/ready handshake, global stall, flush and
// bubble (NOP) insertion. Outputs come straight from the last slot's registers.
// Optional saturating statistics counters: define MEM_WB_PIPE_REG_STATS_EN.
module mem_wb_pipe_reg #(
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_W   = 4,
   parameter int unsigned STAGES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd
`ifdef MEM_WB_PIPE_REG_STATS_EN
   ,
   output logic [15:0]       bubble_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe_reg: STAGES must be in the range 1..4");
   end

   localparam int unsigned LAST = STAGES - 1;

   logic              r_valid [STAGES];
   logic [CTRL_W-1:0] r_ctrl  [STAGES];
   logic [DATA_W-1:0] r_data  [STAGES];
   logic [RD_W-1:0]   r_rd    [STAGES];

   // w_accept[STAGES] stands for the write-back side taking the last slot
   logic [STAGES:0]   w_accept;
   logic [STAGES-1:0] w_move;
   logic [STAGES-1:0] w_load;
   logic              w_run;

   // Ready chain: walk from the last slot back to slot 0 so a full pipeline
   // draining at the output can still accept at the input in the same cycle.
   always_comb begin
      w_run            = ~stall & ~flush;
      w_accept         = '0;
      w_move           = '0;
      w_accept[STAGES] = out_ready;
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_move[LAST-k]   = r_valid[LAST-k] & w_accept[LAST-k+1] & w_run;
         w_accept[LAST-k] = ~r_valid[LAST-k] | w_move[LAST-k];
      end
      in_ready = w_accept[0] & w_run;
   end

   // Slot i receives when the upstream slot (or the input port for slot 0) moves
   always_comb begin
      w_load    = '0;
      w_load[0] = in_valid & in_ready;
      for (int unsigned i = 1; i < STAGES; i++) begin
         w_load[i] = w_move[i-1];
      end
   end

   // Slot registers: reset clears all, flush invalidates, stall freezes;
   // a slot emptied without a refill becomes a NOP bubble (data/rd held)
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctrl[i]  <= '0;
            r_data[i]  <= '0;
            r_rd[i]    <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctrl[i]  <= '0;
         end
      end else if (!stall) begin
         if (w_load[0]) begin
            r_valid[0] <= 1'b1;
            r_ctrl[0]  <= in_ctrl;
            r_data[0]  <= in_data;
            r_rd[0]    <= in_rd;
         end else if (w_move[0]) begin
            r_valid[0] <= 1'b0;
            r_ctrl[0]  <= '0;
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (w_load[i]) begin
               r_valid[i] <= 1'b1;
               r_ctrl[i]  <= r_ctrl[i-1];
               r_data[i]  <= r_data[i-1];
               r_rd[i]    <= r_rd[i-1];
            end else if (w_move[i]) begin
               r_valid[i] <= 1'b0;
               r_ctrl[i]  <= '0;
            end
         end
      end
   end

   assign out_valid = r_valid[LAST];
   assign out_ctrl  = r_ctrl[LAST];
   assign out_data  = r_data[LAST];
   assign out_rd    = r_rd[LAST];

`ifdef MEM_WB_PIPE_REG_STATS_EN
   // Saturating counters of empty-output cycles and stalled cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (!stall && !r_valid[LAST] && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
         if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed bench for mem_wb_pipe_reg with a scoreboard.
// Three instances (STAGES=1,2,3) indexed 0,1,2; one is exercised at a time.
// Entries are pushed on each input handshake and popped/compared on each
// output consumption. Counter checks run when MEM_WB_PIPE_REG_STATS_EN is set.
`timescale 1ns/1ps
module tb_mem_wb_pipe_reg;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] data;
      logic [3:0]  rd;
   } entry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        stall_a     [3];
   logic        flush_a     [3];
   logic        in_valid_a  [3];
   logic        in_ready_a  [3];
   logic [3:0]  in_ctrl_a   [3];
   logic [31:0] in_data_a   [3];
   logic [3:0]  in_rd_a     [3];
   logic        out_valid_a [3];
   logic        out_ready_a [3];
   logic [3:0]  out_ctrl_a  [3];
   logic [31:0] out_data_a  [3];
   logic [3:0]  out_rd_a    [3];
`ifdef MEM_WB_PIPE_REG_STATS_EN
   logic [15:0] bubble_a    [3];
   logic [15:0] stallc_a    [3];
`endif

   entry_t sb[$];
   int     total = 0;
   int     bad   = 0;

   mem_wb_pipe_reg #(.CTRL_W(4), .DATA_W(32), .RD_W(4), .STAGES(1)) u_s1 (
      .clk(clk), .reset(reset), .stall(stall_a[0]), .flush(flush_a[0]),
      .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
      .in_ctrl(in_ctrl_a[0]), .in_data(in_data_a[0]), .in_rd(in_rd_a[0]),
      .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
      .out_ctrl(out_ctrl_a[0]), .out_data(out_data_a[0]), .out_rd(out_rd_a[0])
`ifdef MEM_WB_PIPE_REG_STATS_EN
      , .bubble_cnt(bubble_a[0]), .stall_cnt(stallc_a[0])
`endif
   );

   mem_wb_pipe_reg #(.CTRL_W(4), .DATA_W(32), .RD_W(4), .STAGES(2)) u_s2 (
      .clk(clk), .reset(reset), .stall(stall_a[1]), .flush(flush_a[1]),
      .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
      .in_ctrl(in_ctrl_a[1]), .in_data(in_data_a[1]), .in_rd(in_rd_a[1]),
      .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
      .out_ctrl(out_ctrl_a[1]), .out_data(out_data_a[1]), .out_rd(out_rd_a[1])
`ifdef MEM_WB_PIPE_REG_STATS_EN
      , .bubble_cnt(bubble_a[1]), .stall_cnt(stallc_a[1])
`endif
   );

   mem_wb_pipe_reg #(.CTRL_W(4), .DATA_W(32), .RD_W(4), .STAGES(3)) u_s3 (
      .clk(clk), .reset(reset), .stall(stall_a[2]), .flush(flush_a[2]),
      .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
      .in_ctrl(in_ctrl_a[2]), .in_data(in_data_a[2]), .in_rd(in_rd_a[2]),
      .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
      .out_ctrl(out_ctrl_a[2]), .out_data(out_data_a[2]), .out_rd(out_rd_a[2])
`ifdef MEM_WB_PIPE_REG_STATS_EN
      , .bubble_cnt(bubble_a[2]), .stall_cnt(stallc_a[2])
`endif
   );

   function automatic entry_t mk(input logic [3:0] c, input logic [31:0] d, input logic [3:0] r);
      entry_t e;
      e.ctrl = c;
      e.data = d;
      e.rd   = r;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input entry_t e);
      in_valid_a[d] = v;
      in_ctrl_a[d]  = e.ctrl;
      in_data_a[d]  = e.data;
      in_rd_a[d]    = e.rd;
   endtask

   // One clock cycle on instance d: score the handshakes about to happen,
   // then step past the rising edge.
   task automatic tick(input int d);
      entry_t e;
      #1;
      if (!reset && !stall_a[d] && !flush_a[d] && out_valid_a[d] && out_ready_a[d]) begin
         if (sb.size() == 0) begin
            chk($sformatf("sb_unexpected_out_i%0d", d), 32'(out_valid_a[d]), 32'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("sb_ctrl_i%0d", d), 32'(out_ctrl_a[d]), 32'(e.ctrl));
            chk($sformatf("sb_data_i%0d", d), out_data_a[d], e.data);
            chk($sformatf("sb_rd_i%0d", d), 32'(out_rd_a[d]), 32'(e.rd));
         end
      end
      if (!reset && in_valid_a[d] && in_ready_a[d]) begin
         sb.push_back(mk(in_ctrl_a[d], in_data_a[d], in_rd_a[d]));
      end
      if (reset || flush_a[d]) sb.delete();
      @(posedge clk);
      #1;
   endtask

   entry_t idle_e;
   entry_t ea, eb, ec, ex, ey;
   entry_t es [6];
   entry_t ef [4];

   initial begin
      idle_e = mk(4'h0, 32'h0, 4'h0);
      reset  = 1'b1;
      for (int d = 0; d < 3; d++) begin
         stall_a[d]     = 1'b0;
         flush_a[d]     = 1'b0;
         out_ready_a[d] = 1'b1;
         drive(d, 1'b0, idle_e);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;

      // reset state of every instance
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_out_valid_i%0d", d), 32'(out_valid_a[d]), 32'd0);
         chk($sformatf("rst_out_ctrl_i%0d", d), 32'(out_ctrl_a[d]), 32'd0);
         chk($sformatf("rst_out_data_i%0d", d), out_data_a[d], 32'd0);
         chk($sformatf("rst_out_rd_i%0d", d), 32'(out_rd_a[d]), 32'd0);
         chk($sformatf("rst_in_ready_i%0d", d), 32'(in_ready_a[d]), 32'd1);
      end

      // 1: STAGES=2 latency, single entry then bubble
      sb.delete();
      drive(1, 1'b1, mk(4'b0001, 32'hDEADBEEF, 4'd7));
      tick(1);
      drive(1, 1'b0, idle_e);
      chk("t1_c1_out_valid", 32'(out_valid_a[1]), 32'd0);
      tick(1);
      chk("t1_c2_out_valid", 32'(out_valid_a[1]), 32'd1);
      chk("t1_c2_out_ctrl", 32'(out_ctrl_a[1]), 32'd1);
      chk("t1_c2_out_data", out_data_a[1], 32'hDEADBEEF);
      chk("t1_c2_out_rd", 32'(out_rd_a[1]), 32'd7);
      tick(1);
      chk("t1_c3_out_valid", 32'(out_valid_a[1]), 32'd0);
      chk("t1_c3_out_ctrl", 32'(out_ctrl_a[1]), 32'd0);
      chk("t1_c3_data_held", out_data_a[1], 32'hDEADBEEF);
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);

      // 2: STAGES=2 backpressure, then drain with no bubble
      ea = mk(4'h1, 32'hA000_000A, 4'd1);
      eb = mk(4'h3, 32'hB000_000B, 4'd2);
      ec = mk(4'h5, 32'hC000_000C, 4'd3);
      out_ready_a[1] = 1'b0;
      drive(1, 1'b1, ea);
      #1 chk("t2_a_in_ready", 32'(in_ready_a[1]), 32'd1);
      tick(1);
      drive(1, 1'b1, eb);
      #1 chk("t2_b_in_ready", 32'(in_ready_a[1]), 32'd1);
      tick(1);
      drive(1, 1'b1, ec);
      #1 chk("t2_full_in_ready", 32'(in_ready_a[1]), 32'd0);
      chk("t2_full_out_valid", 32'(out_valid_a[1]), 32'd1);
      chk("t2_full_out_data", out_data_a[1], ea.data);
      tick(1);
      #1 chk("t2_held_in_ready", 32'(in_ready_a[1]), 32'd0);
      chk("t2_held_out_data", out_data_a[1], ea.data);
      out_ready_a[1] = 1'b1;
      #1 chk("t2_resume_in_ready", 32'(in_ready_a[1]), 32'd1);
      tick(1);
      drive(1, 1'b0, idle_e);
      chk("t2_out_b", out_data_a[1], eb.data);
      tick(1);
      chk("t2_out_c", out_data_a[1], ec.data);
      tick(1);
      chk("t2_drained_valid", 32'(out_valid_a[1]), 32'd0);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // 3: STAGES=1 stream with a 3-cycle stall
      for (int k = 0; k < 6; k++) es[k] = mk(4'(k) | 4'h1, 32'h3000_0000 + 32'(k), 4'(k + 8));
      for (int k = 0; k < 3; k++) begin
         drive(0, 1'b1, es[k]);
         tick(0);
      end
      drive(0, 1'b1, es[3]);
      stall_a[0] = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("t3_stall%0d_in_ready", s), 32'(in_ready_a[0]), 32'd0);
         chk($sformatf("t3_stall%0d_out_valid", s), 32'(out_valid_a[0]), 32'd1);
         chk($sformatf("t3_stall%0d_out_data", s), out_data_a[0], es[2].data);
         tick(0);
      end
      stall_a[0] = 1'b0;
      #1 chk("t3_unstall_in_ready", 32'(in_ready_a[0]), 32'd1);
      chk("t3_unstall_out_data", out_data_a[0], es[2].data);
      tick(0);
      chk("t3_resume_out_data", out_data_a[0], es[3].data);
      for (int k = 4; k < 6; k++) begin
         drive(0, 1'b1, es[k]);
         tick(0);
      end
      drive(0, 1'b0, idle_e);
      tick(0);
      chk("t3_drained_valid", 32'(out_valid_a[0]), 32'd0);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // 4: STAGES=3 full, flush together with stall and a valid input
      for (int k = 0; k < 4; k++) ef[k] = mk(4'h9, 32'h4000_0000 + 32'(k), 4'(k));
      ex = mk(4'hF, 32'hBAD0_BAD0, 4'hE);
      ey = mk(4'h1, 32'h5555_AAAA, 4'd5);
      out_ready_a[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(2, 1'b1, ef[k]);
         #1 chk($sformatf("t4_fill%0d_in_ready", k), 32'(in_ready_a[2]), 32'd1);
         tick(2);
      end
      drive(2, 1'b1, ef[3]);
      #1 chk("t4_full_in_ready", 32'(in_ready_a[2]), 32'd0);
      chk("t4_full_out_data", out_data_a[2], ef[0].data);
      drive(2, 1'b1, ex);
      flush_a[2] = 1'b1;
      stall_a[2] = 1'b1;
      #1 chk("t4_flush_in_ready", 32'(in_ready_a[2]), 32'd0);
      tick(2);
      flush_a[2]     = 1'b0;
      stall_a[2]     = 1'b0;
      out_ready_a[2] = 1'b1;
      drive(2, 1'b0, idle_e);
      chk("t4_flushed_valid", 32'(out_valid_a[2]), 32'd0);
      chk("t4_flushed_ctrl", 32'(out_ctrl_a[2]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick(2);
         chk($sformatf("t4_empty%0d_valid", k), 32'(out_valid_a[2]), 32'd0);
      end
      drive(2, 1'b1, ey);
      tick(2);
      drive(2, 1'b0, idle_e);
      tick(2);
      tick(2);
      chk("t4_after_valid", 32'(out_valid_a[2]), 32'd1);
      chk("t4_after_data", out_data_a[2], ey.data);
      tick(2);
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);

      // 5: reset with two entries in flight on STAGES=2
      out_ready_a[1] = 1'b0;
      drive(1, 1'b1, mk(4'h7, 32'h6666_0001, 4'd9));
      tick(1);
      drive(1, 1'b1, mk(4'h3, 32'h6666_0002, 4'd10));
      tick(1);
      drive(1, 1'b0, idle_e);
      chk("t5_pre_out_valid", 32'(out_valid_a[1]), 32'd1);
      reset = 1'b1;
      tick(1);
      reset          = 1'b0;
      out_ready_a[1] = 1'b1;
      #1;
      chk("t5_out_valid", 32'(out_valid_a[1]), 32'd0);
      chk("t5_out_ctrl", 32'(out_ctrl_a[1]), 32'd0);
      chk("t5_out_data", out_data_a[1], 32'd0);
      chk("t5_out_rd", 32'(out_rd_a[1]), 32'd0);
      chk("t5_in_ready", 32'(in_ready_a[1]), 32'd1);

`ifdef MEM_WB_PIPE_REG_STATS_EN
      // 6: bubble and stall counters, including saturation
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("t6_bubble_5", 32'(bubble_a[1]), 32'd5);
      chk("t6_stall_0", 32'(stallc_a[1]), 32'd0);
      stall_a[1] = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("t6_stall_2", 32'(stallc_a[1]), 32'd2);
      chk("t6_bubble_hold", 32'(bubble_a[1]), 32'd5);
      repeat (70000) @(posedge clk);
      #1;
      chk("t6_stall_sat", 32'(stallc_a[1]), 32'h0000_FFFF);
      chk("t6_bubble_still", 32'(bubble_a[1]), 32'd5);
      stall_a[1] = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised elastic pipeline register for the MEM->WB boundary. It is the successor to the fixed 4-bit control-only register.
- Carries WB control bits, a result data word and the destination register index through STAGES back-to-back slots.
- Adds a valid/ready handshake, a global stall, a flush, and bubble (NOP) insertion.
- Sits between the memory-access stage and the register-file write-back logic.

Parameters:
CTRL_W, 4, width of WB control bundle (bit 0 = reg_write enable by convention)
DATA_W, 32, width of result word (ALU result or load data)
RD_W, 4, width of destination register index
STAGES, 1, number of register slots in series; legal range 1..4, other values are a synthesis error

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  freeze all slots; no slot accepts, moves or emits
flush  in  1  invalidate all slots and discard the current input
in_valid  in  1  upstream has a valid entry
in_ready  out  1  slot 0 can accept this cycle
in_ctrl  in  CTRL_W  WB control bits
in_data  in  DATA_W  result word
in_rd  in  RD_W  destination register
out_valid  out  1  last slot holds a valid entry
out_ready  in  1  write-back consumes the entry this cycle
out_ctrl  out  CTRL_W  WB control of last slot; all-zero when out_valid=0
out_data  out  DATA_W  result word of last slot
out_rd  out  RD_W  destination register of last slot

Behaviour:
- Per slot i: valid[i], ctrl[i], data[i], rd[i]. All outputs are driven directly from the last slot's registers; there is no combinational path from in_* to out_*.
- Reset (synchronous, active-high, clock clk): all valid=0, ctrl=0, data=0, rd=0. Outputs after reset: out_valid=0, out_ctrl=0, out_data=0, out_rd=0, in_ready=1 (once reset is low and stall/flush are low).
- Move logic (combinational, evaluated with stall=0 and flush=0):
  - move[last] = valid[last] & out_ready
  - move[i] = valid[i] & accept[i+1]
  - accept[i] = ~valid[i] | move[i]
  - in_ready = accept[0] & ~stall & ~flush
- Register update:
  - A slot that receives an entry loads its payload and sets valid=1.
  - A slot that moves its entry out without receiving a new one sets valid=0 and ctrl=0 (bubble = NOP). Its data and rd hold their previous values.
  - Slot 0 loads when in_valid & in_ready.
- Latency: with out_ready held at 1 and no stall/flush, an input accepted at cycle N appears at the output at cycle N+STAGES. Throughput is 1 entry per cycle.
- Backpressure: with out_ready=0, entries pile up. in_ready drops in the same cycle that all STAGES slots are valid. A full pipeline with out_ready=1 accepts and emits in the same cycle, so there is no bubble.
- stall=1:
  - All registers hold.
  - in_ready=0.
  - out_valid keeps its value, but nothing is consumed even if out_ready=1.
- flush=1:
  - On the next edge all valid=0 and ctrl=0.
  - The input is discarded (in_ready=0).
  - Flush overrides stall.
- Reset mid-operation overrides stall and flush. All slots clear on that edge; in-flight entries are lost by design.
- The in_valid=1 / in_ready=0 case is legal. Upstream must hold its payload; this block samples only on handshake.

Optional Feature:
Macro MEM_WB_PIPE_REG_STATS_EN.
- When defined, two extra output ports are added:
  - bubble_cnt (16 bits): increments on each cycle with out_valid=0, reset=0 and stall=0.
  - stall_cnt (16 bits): increments on each cycle with stall=1 and reset=0.
- Both counters saturate at 16'hFFFF, clear on reset, and are not affected by flush.
- When not defined, the ports and counters do not exist and the datapath behaviour is identical.

Test Plan:
1. Reset then STAGES=2, out_ready=1; in (ctrl=4'b0001, data=32'hDEADBEEF, rd=4'd7) valid at cycle 0 -> out_valid=1 with the same values at cycle 2, and out_valid=0 / out_ctrl=0 at cycle 3.
2. STAGES=2, out_ready=0, stream 3 entries A,B,C -> in_ready=0 after A and B are held; C is held upstream. Raise out_ready -> A, B, C emerge in order on consecutive cycles with no loss or duplication.
3. STAGES=1, stream of entries, assert stall for 3 cycles mid-stream -> out_* and in_ready=0 are frozen for exactly 3 cycles; the sequence resumes intact.
4. STAGES=3 full, assert flush together with stall and in_valid=1 -> next cycle all out_valid=0 and out_ctrl=0; the flushed-cycle input never appears at the output.
5. Assert reset while 2 entries are in flight -> next cycle out_valid=0, out_ctrl=0, out_data=0, out_rd=0, in_ready=1.
6. With MEM_WB_PIPE_REG_STATS_EN defined: 5 idle cycles then 2 stall cycles -> bubble_cnt=5, stall_cnt=2. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
